sfx_arbiter: RTL and testbench

Sound-effect scheduler that owns the on-board mono amplifier (ampPWM/ampSD) and shares it between game event requesters (jump, score, crash). It latches one-cycle request pulses from core, grants the amplifier by fixed priority, and sequences the granted effect's note list from a constant table. For each note it generates a square-wave tone for a fixed duration. It sits beside core/level in project_top and drives the amplifier pins directly.

---
 rtl/sfx_pkg.sv | 43 ++++
 rtl/tone_gen.sv | 43 ++++
 rtl/sfx_arbiter.sv | 156 +++++++++++++++
 tb/tb_sfx_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sfx_pkg
//  Purpose  : Shared types and the constant effect table for sfx_arbiter.
//             Optional feature macro used by the arbiter: SFX_PREEMPT_EN.
//  Revision : 1.0  initial release
// ============================================================================
package sfx_pkg;

    localparam int c_HPW = 18;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [c_HPW-1:0] hp;
        logic [7:0]       dur;
    } note_t;

    // Effect table lookup: id 0 jump, 1 score, 2 crash; unknown ids are empty.
    function automatic note_t sfx_note(input logic [1:0] id, input logic [1:0] idx);
        note_t n;
        n = '{hp: '0, dur: '0};
        case ({id, idx})
            4'b00_00: n = '{hp: 18'd47755,  dur: 8'd60};
            4'b00_01: n = '{hp: 18'd37908,  dur: 8'd60};
            4'b01_00: n = '{hp: 18'd37908,  dur: 8'd40};
            4'b01_01: n = '{hp: 18'd31888,  dur: 8'd40};
            4'b01_10: n = '{hp: 18'd25310,  dur: 8'd80};
            4'b10_00: n = '{hp: 18'd191131, dur: 8'd150};
            4'b10_01: n = '{hp: 18'd0,      dur: 8'd50};
            4'b10_10: n = '{hp: 18'd255102, dur: 8'd250};
            default:  n = '{hp: '0, dur: '0};
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tone_gen
//  Purpose  : Half-period counter producing a registered square wave.
//             hp = 0 holds the output low (rest note).
//  Revision : 1.0  initial release
// ============================================================================
module tone_gen #(
    parameter int HPW = 18
) (
    input  logic           clk,
    input  logic           Reset,
    input  logic           clr,
    input  logic           en,
    input  logic [HPW-1:0] hp,
    output logic           out
);

    logic [HPW-1:0] r_cnt;
    logic           r_out;

    // Count 0..hp-1 while enabled; toggle the output on each wrap.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (clr) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (en && (hp != '0)) begin
            if (r_cnt == hp - HPW'(1)) begin
                r_cnt <= '0;
                r_out <= ~r_out;
            end else begin
                r_cnt <= r_cnt + HPW'(1);
            end
        end
    end

    assign out = r_out;

endmodule
`default_nettype wire

// File: rtl/sfx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sfx_arbiter
//  Purpose  : Latches effect requests, grants the amplifier by fixed priority
//             (highest index wins) and plays the granted effect's notes.
//             Define SFX_PREEMPT_EN to let a higher-priority request abort a
//             playing note; otherwise effects run to completion.
//             HP_SHIFT right-shifts table half-periods (0 = true pitch).
//  Revision : 1.0  initial release
// ============================================================================
module sfx_arbiter
    import sfx_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int TICK_DIV = 100000,
    parameter int HPW      = 18,
    parameter int HP_SHIFT = 0
) (
    input  logic             board_clk,
    input  logic             Reset,
    input  logic [N_REQ-1:0] req,
    output logic             ampPWM,
    output logic             ampSD,
    output logic             busy,
    output logic [1:0]       active_id
);

    localparam int c_PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t           r_state, w_state_nxt;
    logic [N_REQ-1:0] r_pending, w_clr_mask;
    logic [1:0]       r_active_id, w_id_nxt;
    logic [1:0]       r_note_idx, w_idx_nxt;
    logic [c_PW-1:0]  r_presc;
    logic [7:0]       r_ticks;
    logic             r_amp_sd;
    logic             w_grant_vld, w_take;
    logic [1:0]       w_grant_id;
    logic             w_presc_wrap, w_note_end;
    logic [HPW-1:0]   w_hp;
    note_t            w_note;

    assign w_note       = sfx_note(r_active_id, r_note_idx);
    assign w_hp         = HPW'(w_note.hp >> HP_SHIFT);
    assign w_presc_wrap = (r_presc == c_PW'(TICK_DIV - 1));
    assign w_note_end   = (r_state == S_PLAY) && w_presc_wrap && (r_ticks + 8'd1 == w_note.dur);

    // Priority encoder: the highest set pending bit is the candidate grant.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = 2'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_pending[i]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = 2'(i);
            end
        end
    end

    // Next-state logic; w_take marks the cycle a grant is issued.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_id_nxt    = r_active_id;
        w_idx_nxt   = r_note_idx;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_grant_vld) begin
                    w_take      = 1'b1;
                    w_id_nxt    = w_grant_id;
                    w_idx_nxt   = 2'd0;
                    w_state_nxt = S_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                w_state_nxt = (w_note.dur == 8'd0) ? S_DONE : S_PLAY;
            end
            S_PLAY: begin
                if (w_note_end) begin
                    if (r_note_idx == 2'd3) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt   = r_note_idx + 2'd1;
                        w_state_nxt = S_LOAD;
                    end
                end
`ifdef SFX_PREEMPT_EN
                if (w_grant_vld && (w_grant_id > r_active_id)) begin
                    w_take      = 1'b1;
                    w_id_nxt    = w_grant_id;
                    w_idx_nxt   = 2'd0;
                    w_state_nxt = S_LOAD;
                end
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A granted bit clears, but a request arriving the same cycle re-pends it.
    assign w_clr_mask = w_take ? (N_REQ'(1) << w_grant_id) : '0;

    // State, grant bookkeeping and amplifier enable registers.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_pending   <= '0;
            r_active_id <= 2'd0;
            r_note_idx  <= 2'd0;
            r_amp_sd    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pending   <= (r_pending & ~w_clr_mask) | req;
            r_active_id <= w_id_nxt;
            r_note_idx  <= w_idx_nxt;
            r_amp_sd    <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_PLAY);
        end
    end

    // Duration timing: prescaler and tick count run only in PLAY.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            r_presc <= '0;
            r_ticks <= 8'd0;
        end else if (r_state == S_PLAY) begin
            if (w_presc_wrap) begin
                r_presc <= '0;
                r_ticks <= r_ticks + 8'd1;
            end else begin
                r_presc <= r_presc + c_PW'(1);
            end
        end else begin
            r_presc <= '0;
            r_ticks <= 8'd0;
        end
    end

    tone_gen #(
        .HPW (HPW)
    ) u_tone (
        .clk   (board_clk),
        .Reset (Reset),
        .clr   (w_state_nxt != S_PLAY),
        .en    (r_state == S_PLAY),
        .hp    (w_hp),
        .out   (ampPWM)
    );

    assign ampSD     = r_amp_sd;
    assign busy      = (r_state != S_IDLE);
    assign active_id = r_active_id;

endmodule
`default_nettype wire

// File: tb/tb_sfx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sfx_arbiter
//  Purpose  : Self-checking bench for sfx_arbiter against a timeline model
//             of each effect (offsets since grant -> LOAD/PLAY/DONE phase).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sfx_arbiter;

    localparam int TD = 4;
    localparam int SH = 10;

    logic       board_clk = 1'b0;
    logic       Reset     = 1'b1;
    logic [2:0] req       = 3'b000;
    logic       ampPWM, ampSD, busy;
    logic [1:0] active_id;

    sfx_arbiter #(
        .N_REQ    (3),
        .TICK_DIV (TD),
        .HPW      (18),
        .HP_SHIFT (SH)
    ) dut (
        .board_clk (board_clk),
        .Reset     (Reset),
        .req       (req),
        .ampPWM    (ampPWM),
        .ampSD     (ampSD),
        .busy      (busy),
        .active_id (active_id)
    );

    always #5 board_clk = ~board_clk;

    int m_hp  [3][4] = '{'{47755, 37908, 0, 0}, '{37908, 31888, 25310, 0}, '{191131, 0, 255102, 0}};
    int m_dur [3][4] = '{'{60, 60, 0, 0}, '{40, 40, 80, 0}, '{150, 50, 250, 0}};

    // Model state: mode 0 idle, 1 playing (offset since first LOAD), 2 done.
    int       m_mode;
    int       m_id;
    int       m_off;
    bit [2:0] m_pend;

    int n_total = 0;
    int n_pass  = 0;

    function automatic int eff_len(input int id);
        int l = 0;
        for (int k = 0; k < 4; k++) begin
            if (m_dur[id][k] == 0) return l + 1;
            l += 1 + m_dur[id][k] * TD;
        end
        return l;
    endfunction

    function automatic void phase(input int id, input int off, output bit is_play, output bit pwm);
        int o = off;
        int hp, p;
        is_play = 1'b0;
        pwm     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (o == 0 || m_dur[id][k] == 0) return;
            if (o <= m_dur[id][k] * TD) begin
                is_play = 1'b1;
                hp = m_hp[id][k] >> SH;
                p  = o - 1;
                pwm = (hp == 0) ? 1'b0 : bit'((p / hp) % 2);
                return;
            end
            o -= 1 + m_dur[id][k] * TD;
        end
    endfunction

    function automatic int hi_bit(input bit [2:0] p);
        int g = 0;
        for (int i = 0; i < 3; i++) if (p[i]) g = i;
        return g;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_id   = 0;
        m_off  = 0;
        m_pend = 3'b000;
    endtask

    task automatic model_grant(input bit [2:0] p);
        m_id   = hi_bit(p);
        m_pend[m_id] = 1'b0;
        m_mode = 1;
        m_off  = 0;
    endtask

    task automatic model_step(input bit [2:0] r);
        bit [2:0] p = m_pend;
        bit       pl, pw;
        bit       pre = 1'b0;
        case (m_mode)
            0: if (p != 0) model_grant(p);
            1: begin
                phase(m_id, m_off, pl, pw);
`ifdef SFX_PREEMPT_EN
                pre = pl && (p != 0) && (hi_bit(p) > m_id);
`endif
                if (pre) model_grant(p);
                else begin
                    m_off++;
                    if (m_off == eff_len(m_id)) m_mode = 2;
                end
            end
            default: begin
                if (p != 0) model_grant(p);
                else m_mode = 0;
            end
        endcase
        m_pend = m_pend | r;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    endtask

    task automatic check_all();
        bit pl, pw;
        bit e_sd, e_pwm, e_busy;
        e_sd = 1'b0; e_pwm = 1'b0; e_busy = (m_mode != 0);
        if (m_mode == 1) begin
            phase(m_id, m_off, pl, pw);
            e_sd  = 1'b1;
            e_pwm = pw;
        end
        chk("ampSD",     32'(ampSD),           32'(e_sd));
        chk("ampPWM",    32'(ampPWM),          32'(e_pwm));
        chk("busy",      32'(busy),            32'(e_busy));
        chk("active_id", 32'(active_id),       32'(m_id));
        chk("pending",   32'(dut.r_pending),   32'(m_pend));
    endtask

    task automatic tick(input logic [2:0] r);
        req = r;
        @(posedge board_clk);
        if (Reset) model_reset();
        else model_step(r);
        #1;
        check_all();
        req = 3'b000;
    endtask

    task automatic run_until_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            tick(3'b000);
            if (m_mode == 0) break;
        end
        chk("idle_reached", 32'(busy), 32'(0));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(3'b000);
    endtask

    initial begin
        model_reset();

        // Reset held, then released with no requests.
        run(5);
        Reset = 1'b0;
        run(1000);

        // Single jump effect from idle.
        tick(3'b001);
        run_until_idle(2000);
        run(3);

        // All three requested together: crash, score, jump in turn.
        tick(3'b111);
        run_until_idle(8000);
        run(3);

        // Crash requested while jump plays.
        tick(3'b001);
        run(100);
        tick(3'b100);
        run_until_idle(8000);
        run(3);

        // Re-request of the playing effect replays it afterwards.
        tick(3'b010);
        run(50);
        tick(3'b010);
        run_until_idle(4000);
        run(3);

        // Asynchronous reset mid-score with jump pending.
        tick(3'b010);
        run(60);
        tick(3'b001);
        run(20);
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        chk("async_ampSD",  32'(ampSD),         32'(0));
        chk("async_ampPWM", 32'(ampPWM),        32'(0));
        chk("async_busy",   32'(busy),          32'(0));
        chk("async_id",     32'(active_id),     32'(0));
        chk("async_pend",   32'(dut.r_pending), 32'(0));
        run(3);
        Reset = 1'b0;
        run(300);

        // Randomized sparse requests.
        for (int i = 0; i < 25000; i++) begin
            if ($urandom_range(0, 99) < 3) tick(3'($urandom_range(1, 7)));
            else tick(3'b000);
        end
        run_until_idle(8000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
